// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-atomic merge of CHANNELS AXI-stream inputs.
// One-entry output register tags each beat with its source channel.
module axis_packet_arbiter #(
  parameter int DWIDTH      = 32,
  parameter int CHANNELS    = 8,
  parameter bit PACKET_MODE = 1'b1,
  parameter int IDW         = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS*DWIDTH-1:0] s_data,
  input  logic [CHANNELS-1:0]        s_valid,
  input  logic [CHANNELS-1:0]        s_last,
  output logic [CHANNELS-1:0]        s_ready,
  output logic [DWIDTH-1:0]          m_data,
  output logic                       m_valid,
  output logic                       m_last,
  output logic [IDW-1:0]             m_id,
  input  logic                       m_ready,
  output logic                       busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [DWIDTH-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [IDW-1:0]    m_id_q, m_id_d;

  logic [IDW-1:0]    pick;
  logic [IDW-1:0]    idx;
  logic              any_req;
  logic              load_en;
  logic              accept;

  assign load_en = ~m_valid_q | m_ready;

  // Rotating-priority search starting at rr_q.
  always_comb begin
    pick    = rr_q;
    idx     = rr_q;
    any_req = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = IDW'((int'(rr_q) + k) % CHANNELS);
      if (!any_req && s_valid[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  // Next-state, grant, pointer and output-register load.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_id_d    = m_id_q;
    m_valid_d = m_valid_q & ~m_ready;
    s_ready   = '0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        s_ready[grant_q] = load_en;
        accept = s_valid[grant_q] & load_en;
        if (accept) begin
          m_data_d  = s_data[int'(grant_q)*DWIDTH +: DWIDTH];
          m_last_d  = s_last[grant_q];
          m_id_d    = grant_q;
          m_valid_d = 1'b1;
          if (s_last[grant_q] || !PACKET_MODE) begin
            state_d = IDLE;
            rr_d    = IDW'((int'(grant_q) + 1) % CHANNELS);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_id_q    <= m_id_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_id    = m_id_q;
  assign busy    = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed vector table plus scoreboarded traffic runs
// for the packet arbiter (4 channels, both packet modes).
module tb_axis_packet_arbiter;

  localparam int NV = 28;

  logic         clk;
  logic         reset;
  logic [127:0] s_data;
  logic [3:0]   s_valid;
  logic [3:0]   s_last;
  logic         m_ready;

  logic [3:0]  s_ready1, s_ready0;
  logic [31:0] m_data1, m_data0;
  logic        m_valid1, m_valid0;
  logic        m_last1, m_last0;
  logic [1:0]  m_id1, m_id0;
  logic        busy1, busy0;

  logic        sel_pm0;
  logic [3:0]  sr;
  logic [31:0] md;
  logic        mv, ml;
  logic [1:0]  mid;

  assign sr  = sel_pm0 ? s_ready0 : s_ready1;
  assign md  = sel_pm0 ? m_data0 : m_data1;
  assign mv  = sel_pm0 ? m_valid0 : m_valid1;
  assign ml  = sel_pm0 ? m_last0 : m_last1;
  assign mid = sel_pm0 ? m_id0 : m_id1;

  axis_packet_arbiter #(
    .DWIDTH(32), .CHANNELS(4), .PACKET_MODE(1'b1), .IDW(2)
  ) u_dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1),
    .m_id(m_id1), .m_ready(m_ready), .busy(busy1)
  );

  axis_packet_arbiter #(
    .DWIDTH(32), .CHANNELS(4), .PACKET_MODE(1'b0), .IDW(2)
  ) u_dut0 (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready0),
    .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0),
    .m_id(m_id0), .m_ready(m_ready), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] sv;
    logic [3:0] sl;
    logic [7:0] d;
    logic       mr;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic [1:0] eid;
    logic [3:0] er;
    logic       eb;
    logic       full;
  } vec_t;

  vec_t tbl [NV];

  int nvec;
  int nerr;

  logic [31:0] bd [4][256];
  logic        bl [4][256];
  int          wr [4];
  int          rd [4];
  int          chk [4];
  int          pkt_ids [64];
  int          beat_ids [64];
  int          npk, nbt;
  int          first_c, last_c;

  task automatic expect_eq(input string nm, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic tb_reset();
    reset   = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      wr[c] = 0; rd[c] = 0; chk[c] = 0;
    end
    npk = 0; nbt = 0; first_c = -1; last_c = -1;
  endtask

  task automatic add_pkt(input int c, input int len);
    for (int b = 0; b < len; b++) begin
      bd[c][wr[c]] = {4'(c), 20'(wr[c]), 8'(b)};
      bl[c][wr[c]] = (b == len - 1);
      wr[c]++;
    end
  endtask

  task automatic run_traffic(input bit pm0, input bit rnd,
                             input int budget);
    int          cyc;
    bit          inpkt;
    bit          done;
    logic [1:0]  cur;
    logic [3:0]  fire;
    bit          macc;
    logic [31:0] od;
    logic        ol;
    logic [1:0]  oid;
    int          o;
    cyc = 0; inpkt = 0; cur = '0;
    forever begin
      for (int c = 0; c < 4; c++) begin
        s_valid[c] = (rd[c] < wr[c]) &&
                     (!rnd || $urandom_range(0, 3) != 0);
        if (rd[c] < wr[c]) begin
          s_data[c*32 +: 32] = bd[c][rd[c]];
          s_last[c] = bl[c][rd[c]];
        end else begin
          s_data[c*32 +: 32] = '0;
          s_last[c] = 1'b0;
        end
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      fire = s_valid & sr;
      macc = mv & m_ready;
      od = md; ol = ml; oid = mid;
      @(posedge clk); #1;
      cyc++;
      for (int c = 0; c < 4; c++)
        if (fire[c]) rd[c]++;
      if (macc) begin
        o = int'(oid);
        nvec++;
        if (!pm0 && inpkt && oid != cur) begin
          nerr++;
          $display("FAIL interleave: got id %0d want %0d", oid, cur);
        end else if (chk[o] >= wr[o]) begin
          nerr++;
          $display("FAIL extra beat: got id %0d data %h", oid, od);
        end else if (od != bd[o][chk[o]] || ol != bl[o][chk[o]]) begin
          nerr++;
          $display("FAIL beat ch%0d: got %h/%0b want %h/%0b",
                   o, od, ol, bd[o][chk[o]], bl[o][chk[o]]);
        end
        if (chk[o] < wr[o]) chk[o]++;
        if (nbt < 64) beat_ids[nbt] = o;
        nbt++;
        if (!inpkt) begin
          if (npk < 64) pkt_ids[npk] = o;
          npk++;
        end
        inpkt = !ol;
        cur   = oid;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      done = 1'b1;
      for (int c = 0; c < 4; c++)
        if (chk[c] != wr[c]) done = 1'b0;
      if (done) break;
      if (cyc >= budget) begin
        nvec++;
        nerr++;
        $display("FAIL timeout: got %0d cycles want done", cyc);
        break;
      end
    end
    s_valid = '0;
    m_ready = 1'b1;
  endtask

  initial begin
    nvec = 0; nerr = 0;
    sel_pm0 = 1'b0;
    reset = 1'b0; s_valid = '0; s_last = '0;
    s_data = '0; m_ready = 1'b0;

    // single channel 2, five beats
    tbl[0]  = '{1'b0,4'h0,4'h0,8'h00,1'b0, 1'b0,8'h00,1'b0,2'd0,4'h0,1'b0,1'b1};
    tbl[1]  = '{1'b1,4'h4,4'h0,8'h20,1'b1, 1'b0,8'h00,1'b0,2'd0,4'h4,1'b1,1'b0};
    tbl[2]  = '{1'b1,4'h4,4'h0,8'h20,1'b1, 1'b1,8'h20,1'b0,2'd2,4'h4,1'b1,1'b0};
    tbl[3]  = '{1'b1,4'h4,4'h0,8'h21,1'b1, 1'b1,8'h21,1'b0,2'd2,4'h4,1'b1,1'b0};
    tbl[4]  = '{1'b1,4'h4,4'h0,8'h22,1'b1, 1'b1,8'h22,1'b0,2'd2,4'h4,1'b1,1'b0};
    tbl[5]  = '{1'b1,4'h4,4'h0,8'h23,1'b1, 1'b1,8'h23,1'b0,2'd2,4'h4,1'b1,1'b0};
    tbl[6]  = '{1'b1,4'h4,4'h4,8'h24,1'b1, 1'b1,8'h24,1'b1,2'd2,4'h0,1'b0,1'b0};
    tbl[7]  = '{1'b1,4'h0,4'h0,8'h00,1'b1, 1'b0,8'h00,1'b0,2'd0,4'h0,1'b0,1'b0};
    // channel 1 under backpressure
    tbl[8]  = '{1'b1,4'h2,4'h0,8'h10,1'b1, 1'b0,8'h00,1'b0,2'd0,4'h2,1'b1,1'b0};
    tbl[9]  = '{1'b1,4'h2,4'h0,8'h10,1'b1, 1'b1,8'h10,1'b0,2'd1,4'h2,1'b1,1'b0};
    tbl[10] = '{1'b1,4'h2,4'h0,8'h11,1'b0, 1'b1,8'h10,1'b0,2'd1,4'h0,1'b1,1'b0};
    tbl[11] = '{1'b1,4'h2,4'h0,8'h11,1'b0, 1'b1,8'h10,1'b0,2'd1,4'h0,1'b1,1'b0};
    tbl[12] = '{1'b1,4'h2,4'h0,8'h11,1'b1, 1'b1,8'h11,1'b0,2'd1,4'h2,1'b1,1'b0};
    tbl[13] = '{1'b1,4'h2,4'h0,8'h12,1'b0, 1'b1,8'h11,1'b0,2'd1,4'h0,1'b1,1'b0};
    tbl[14] = '{1'b1,4'h2,4'h0,8'h12,1'b1, 1'b1,8'h12,1'b0,2'd1,4'h2,1'b1,1'b0};
    tbl[15] = '{1'b1,4'h2,4'h2,8'h13,1'b1, 1'b1,8'h13,1'b1,2'd1,4'h0,1'b0,1'b0};
    tbl[16] = '{1'b1,4'h0,4'h0,8'h00,1'b0, 1'b1,8'h13,1'b1,2'd1,4'h0,1'b0,1'b0};
    tbl[17] = '{1'b1,4'h0,4'h0,8'h00,1'b1, 1'b0,8'h00,1'b0,2'd0,4'h0,1'b0,1'b0};
    // reset mid-packet, then ch0 wins over ch1
    tbl[18] = '{1'b1,4'h2,4'h0,8'h30,1'b1, 1'b0,8'h00,1'b0,2'd0,4'h2,1'b1,1'b0};
    tbl[19] = '{1'b1,4'h2,4'h0,8'h30,1'b1, 1'b1,8'h30,1'b0,2'd1,4'h2,1'b1,1'b0};
    tbl[20] = '{1'b1,4'h2,4'h0,8'h31,1'b1, 1'b1,8'h31,1'b0,2'd1,4'h2,1'b1,1'b0};
    tbl[21] = '{1'b0,4'h2,4'h0,8'h32,1'b1, 1'b0,8'h00,1'b0,2'd0,4'h0,1'b0,1'b1};
    tbl[22] = '{1'b1,4'h3,4'h0,8'h32,1'b1, 1'b0,8'h00,1'b0,2'd0,4'h1,1'b1,1'b0};
    tbl[23] = '{1'b1,4'h3,4'h1,8'h40,1'b1, 1'b1,8'h40,1'b1,2'd0,4'h0,1'b0,1'b0};
    tbl[24] = '{1'b1,4'h2,4'h0,8'h32,1'b1, 1'b0,8'h00,1'b0,2'd0,4'h2,1'b1,1'b0};
    tbl[25] = '{1'b1,4'h0,4'h0,8'h32,1'b1, 1'b0,8'h00,1'b0,2'd0,4'h2,1'b1,1'b0};
    tbl[26] = '{1'b1,4'h2,4'h2,8'h32,1'b1, 1'b1,8'h32,1'b1,2'd1,4'h0,1'b0,1'b0};
    tbl[27] = '{1'b1,4'h0,4'h0,8'h00,1'b1, 1'b0,8'h00,1'b0,2'd0,4'h0,1'b0,1'b0};

    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) begin
      reset   = tbl[i].rst;
      s_valid = tbl[i].sv;
      s_last  = tbl[i].sl;
      s_data  = {4{24'h0, tbl[i].d}};
      m_ready = tbl[i].mr;
      @(posedge clk); #1;
      nvec++;
      if (mv != tbl[i].ev || sr != tbl[i].er || busy1 != tbl[i].eb ||
          ((tbl[i].ev || tbl[i].full) &&
           (md != {24'h0, tbl[i].ed} || ml != tbl[i].el ||
            mid != tbl[i].eid))) begin
        nerr++;
        $display("FAIL vec%0d: got v=%0b d=%h l=%0b id=%0d rdy=%b busy=%0b want v=%0b d=%h l=%0b id=%0d rdy=%b busy=%0b",
                 i, mv, md, ml, mid, sr, busy1, tbl[i].ev, tbl[i].ed,
                 tbl[i].el, tbl[i].eid, tbl[i].er, tbl[i].eb);
      end
    end

    // all four channels, two 3-beat packets each
    tb_reset();
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 4; c++)
        add_pkt(c, 3);
    run_traffic(1'b0, 1'b0, 500);
    expect_eq("rr_pkt_count", npk, 8);
    for (int k = 0; k < 8; k++)
      expect_eq($sformatf("rr_order%0d", k), pkt_ids[k], k % 4);
    expect_eq("rr_span", last_c - first_c + 1, 31);

    // per-beat arbitration between ch0 and ch3
    sel_pm0 = 1'b1;
    tb_reset();
    add_pkt(0, 3);
    add_pkt(3, 3);
    run_traffic(1'b1, 1'b0, 500);
    expect_eq("pm0_beats", nbt, 6);
    for (int k = 0; k < 6; k++)
      expect_eq($sformatf("pm0_id%0d", k), beat_ids[k],
                (k % 2 == 0) ? 0 : 3);

    // random soak with backpressure and gappy valids
    sel_pm0 = 1'b0;
    tb_reset();
    for (int p = 0; p < 12; p++)
      for (int c = 0; c < 4; c++)
        add_pkt(c, $urandom_range(1, 16));
    run_traffic(1'b0, 1'b1, 20000);
    for (int c = 0; c < 4; c++)
      expect_eq($sformatf("soak_ch%0d", c), chk[c], wr[c]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
